// File: rtl/axis_layer_deserializer_pkg.sv
// Shared definitions for the layer stream transmitter / deserializer pair:
// default frame geometry and the receiver state encoding.
package axis_layer_deserializer_pkg;

    localparam int LAYER_N_WORDS = 18;
    localparam int LAYER_DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_STALL = 2'd1,
        ST_DROP  = 2'd2
    } layer_rx_state_t;

endpackage

// File: rtl/axis_layer_deserializer.sv
// Collects N_WORDS stream beats into one flat frame for the next layer,
// holding the last beat back while the previous frame is still unconsumed.
module axis_layer_deserializer
    import axis_layer_deserializer_pkg::*;
#(
    parameter int N_WORDS     = LAYER_N_WORDS,
    parameter int DATA_W      = LAYER_DATA_W,
    parameter int CHECK_TLAST = 0
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [DATA_W-1:0]           s_tdata,
    input  logic                        s_tvalid,
    input  logic                        s_tlast,
    output logic                        s_tready,
    output logic [N_WORDS*DATA_W-1:0]   a_flat,
    output logic                        frame_valid,
    output logic                        start,
    input  logic                        frame_ack,
    output logic                        frame_err
);

    localparam int              IDX_W    = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [IDX_W-1:0] PENULT   = IDX_W'(N_WORDS - 2);

    layer_rx_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] shadow [0:N_WORDS-2];

    logic beat;
    logic shadow_we;
    logic load;
    logic err;

    always_comb begin
        s_tready = 1'b0;
        case (state_q)
            ST_RECV:  s_tready = 1'b1;
            ST_STALL: s_tready = frame_ack;
            ST_DROP:  s_tready = 1'b1;
            default:  s_tready = 1'b0;
        endcase
        if (!resetn) s_tready = 1'b0;
    end

    assign beat = s_tvalid && s_tready;

    // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_we = 1'b0;
        load      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_RECV, ST_STALL: begin
                if (beat) begin
                    if (idx_q != LAST_IDX) begin
                        if (CHECK_TLAST != 0 && s_tlast) begin
                            err   = 1'b1;
                            idx_d = '0;
                        end else begin
                            shadow_we = 1'b1;
                            idx_d     = idx_q + IDX_W'(1);
                            // Previous frame still held: the last beat must wait for an ack.
                            if (idx_q == PENULT && frame_valid && !frame_ack)
                                state_d = ST_STALL;
                        end
                    end else if (CHECK_TLAST != 0 && !s_tlast) begin
                        err     = 1'b1;
                        idx_d   = '0;
                        state_d = ST_DROP;
                    end else begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = ST_RECV;
                    end
                end else if (state_q == ST_STALL && frame_ack) begin
                    state_d = ST_RECV;
                end
            end
            ST_DROP: begin
                if (beat && s_tlast) state_d = ST_RECV;
            end
            default: state_d = ST_RECV;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_RECV;
            idx_q       <= '0;
            frame_valid <= 1'b0;
            start       <= 1'b0;
            frame_err   <= 1'b0;
            a_flat      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            start     <= load;
            frame_err <= err;
            if (load) begin
                frame_valid <= 1'b1;
                for (int k = 0; k < N_WORDS - 1; k++)
                    a_flat[k*DATA_W +: DATA_W] <= shadow[k];
                a_flat[(N_WORDS-1)*DATA_W +: DATA_W] <= s_tdata;
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end

    // NOTE: the shadow array is deliberately left out of reset; idx restarts at 0 so stale entries are always overwritten before use.
    always_ff @(posedge clk) begin
        if (shadow_we) shadow[idx_q] <= s_tdata;
    end

endmodule

// File: tb/tb_axis_layer_deserializer.sv
// Directed-plus-random bench for axis_layer_deserializer, checked each cycle
// against a word-queue model of the framing rules.
module tb_axis_layer_deserializer;
    import axis_layer_deserializer_pkg::*;

    localparam int N  = LAYER_N_WORDS;
    localparam int DW = LAYER_DATA_W;
    localparam int FW = N * DW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [FW-1:0] a_flat;
    logic          frame_valid;
    logic          start;
    logic          frame_ack = 1'b0;
    logic          frame_err;

    always #5 clk = ~clk;

    axis_layer_deserializer #(
        .N_WORDS    (N),
        .DATA_W     (DW),
        .CHECK_TLAST(1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .a_flat     (a_flat),
        .frame_valid(frame_valid),
        .start      (start),
        .frame_ack  (frame_ack),
        .frame_err  (frame_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: words of the frame being collected, plus the last delivered frame.
    logic [DW-1:0] m_words[$];
    logic [FW-1:0] m_flat;
    logic          m_fv, m_start, m_err, m_drop;

    int ack_pct  = 0;
    int idle_pct = 0;
    int dut_starts = 0;
    int dut_errs   = 0;

    task automatic check(input string tag, input logic [FW-1:0] observed, input logic [FW-1:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_flat  = '0;
        m_fv    = 1'b0;
        m_start = 1'b0;
        m_err   = 1'b0;
        m_drop  = 1'b0;
    endtask

    task automatic check_outputs();
        check("frame_valid", FW'(frame_valid), FW'(m_fv));
        check("start", FW'(start), FW'(m_start));
        check("frame_err", FW'(frame_err), FW'(m_err));
        check("a_flat", a_flat, m_flat);
    endtask

    // One clock: drive at negedge, check ready, update model at the edge, check outputs after it.
    task automatic cycle(input logic valid, input logic [DW-1:0] data, input logic tlast, output logic accepted);
        logic ack, exp_ready, load;
        @(negedge clk);
        ack = ($urandom_range(99) < ack_pct);
        s_tvalid  = valid;
        s_tdata   = data;
        s_tlast   = tlast;
        frame_ack = ack;
        #1;
        exp_ready = m_drop || ack || !(m_fv && m_words.size() == N - 1);
        check("s_tready", FW'(s_tready), FW'(exp_ready));
        accepted = valid && exp_ready;
        load    = 1'b0;
        m_start = 1'b0;
        m_err   = 1'b0;
        if (accepted) begin
            if (m_drop) begin
                if (tlast) m_drop = 1'b0;
            end else if (m_words.size() < N - 1) begin
                if (tlast) begin
                    m_err = 1'b1;
                    m_words.delete();
                end else begin
                    m_words.push_back(data);
                end
            end else if (!tlast) begin
                m_err  = 1'b1;
                m_drop = 1'b1;
                m_words.delete();
            end else begin
                m_words.push_back(data);
                for (int k = 0; k < N; k++) m_flat[k*DW +: DW] = m_words[k];
                m_words.delete();
                load    = 1'b1;
                m_start = 1'b1;
                m_fv    = 1'b1;
            end
        end
        if (!load && ack) m_fv = 1'b0;
        @(posedge clk);
        #1;
        if (start === 1'b1) dut_starts++;
        if (frame_err === 1'b1) dut_errs++;
        check_outputs();
    endtask

    task automatic send_word(input logic [DW-1:0] data, input logic tlast);
        logic acc;
        int   idle;
        idle = 0;
        while (idle < 8 && $urandom_range(99) < idle_pct) begin
            cycle(1'b0, DW'($urandom), 1'b0, acc);
            idle++;
        end
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) cycle(1'b1, data, tlast, acc);
        check("send_timeout", FW'(acc), FW'(1));
    endtask

    task automatic send_seq(input int count, input logic [DW-1:0] base, input bit rnd, input int tlast_at);
        for (int i = 0; i < count; i++)
            send_word(rnd ? DW'($urandom) : base + DW'(i), i == tlast_at);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        resetn    = 1'b0;
        s_tvalid  = 1'b1;
        s_tdata   = DW'($urandom);
        s_tlast   = 1'b0;
        frame_ack = 1'b0;
        model_reset();
        for (int c = 0; c < cycles; c++) begin
            #1;
            check("reset_tready", FW'(s_tready), FW'(0));
            @(posedge clk);
            #1;
            check_outputs();
            @(negedge clk);
        end
        resetn   = 1'b1;
        s_tvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        model_reset();

        // Reset state, then a plain frame with no ack
        do_reset(3);
        ack_pct = 0;
        idle_pct = 0;
        send_seq(N, 32'h100, 1'b0, N - 1);
        for (int k = 0; k < N; k++)
            check("frame0_word", FW'(a_flat[k*DW +: DW]), FW'(32'h100 + k));
        check("frame0_valid", FW'(frame_valid), FW'(1));
        check("frame0_start", FW'(start), FW'(1));

        // Second frame while the first is still held: last word stalls until ack
        send_seq(N - 1, 32'h200, 1'b0, -1);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 32'h200 + DW'(N - 1), 1'b1, acc);
            check("stall_tready", FW'(s_tready), FW'(0));
        end
        ack_pct = 100;
        cycle(1'b1, 32'h200 + DW'(N - 1), 1'b1, acc);
        check("reload_fv", FW'(frame_valid), FW'(1));
        check("reload_start", FW'(start), FW'(1));
        for (int k = 0; k < N; k++)
            check("frame1_word", FW'(a_flat[k*DW +: DW]), FW'(32'h200 + k));
        cycle(1'b0, '0, 1'b0, acc);
        check("ack_clears", FW'(frame_valid), FW'(0));

        // Random data, 30% idle, random ack
        ack_pct = 40;
        idle_pct = 30;
        for (int f = 0; f < 5; f++) send_seq(N, '0, 1'b1, N - 1);

        // Framing errors: early tlast, then missing tlast with drop until tlast
        idle_pct = 10;
        dut_errs = 0;
        send_seq(6, 32'h300, 1'b0, 5);
        send_seq(N, 32'h400, 1'b0, N - 1);
        send_seq(N, 32'h500, 1'b0, -1);
        send_seq(4, 32'h600, 1'b0, 3);
        send_seq(N, 32'h700, 1'b0, N - 1);
        ack_pct = 100;
        cycle(1'b0, '0, 1'b0, acc);
        check("err_pulses", FW'(dut_errs), FW'(2));

        // Reset in the middle of a frame
        ack_pct = 0;
        idle_pct = 0;
        send_seq(9, 32'h50, 1'b0, -1);
        do_reset(2);
        send_seq(N, 32'hA0, 1'b0, N - 1);
        for (int k = 0; k < N; k++)
            check("post_reset_word", FW'(a_flat[k*DW +: DW]), FW'(32'hA0 + k));

        // Continuous upstream stream with prompt downstream consumption
        ack_pct = 100;
        dut_starts = 0;
        for (int f = 0; f < 3; f++) send_seq(N, '0, 1'b1, N - 1);
        cycle(1'b0, '0, 1'b0, acc);
        check("b2b_frames", FW'(dut_starts), FW'(3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
